// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot controller: fetches from boot ROM, streams loader words into RAM, then switches to RAM.
// Optional checksum verification of the loaded image is enabled with `define IMEM_CHECKSUM_EN.
module imem_boot_ctrl #(
    parameter int ADDR_W       = 14,
    parameter int RESET_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       pc,
    output logic [15:0]       instruction,
    output logic [7:0]        rom_addr,
    input  logic [15:0]       rom_data,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [15:0]       ram_rdata,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [15:0]       ram_wdata,
    output logic              ram_we,
    input  logic              wr_valid,
    input  logic [15:0]       wr_data,
    output logic              wr_ready,
    input  logic              boot_done,
    input  logic              reboot,
    output logic              cpu_reset,
    output logic              run_mode,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count,
`ifdef IMEM_CHECKSUM_EN
    input  logic [15:0]       expected_sum,
    output logic              sum_error,
`endif
    output logic [2:0]        state_dbg
);

    // Handshake: a word transfers on a rising edge where wr_valid && wr_ready; wr_ready
    // never depends on wr_valid, and wr_valid while wr_ready=0 in BOOT marks overflow.

    typedef enum logic [2:0] {
        S_HOLD_ROM = 3'd0,
        S_BOOT     = 3'd1,
        S_HOLD_RAM = 3'd2,
        S_RUN      = 3'd3
`ifdef IMEM_CHECKSUM_EN
        ,
        S_ERROR    = 3'd4
`endif
    } state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [7:0]      HOLD_INIT  = 8'(RESET_CYCLES - 1);

    state_t            state_q, state_d;
    logic [7:0]        hold_q, hold_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              src_ram_q, src_ram_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              wr_ready_q, wr_ready_d;
    logic              run_mode_q, run_mode_d;
    logic              accept;
`ifdef IMEM_CHECKSUM_EN
    logic [15:0]       sum_q, sum_d;
    logic              sum_err_q, sum_err_d;
`endif

    // wr_ready_q is only ever high in BOOT with space left, so it fully qualifies acceptance.
    assign accept = wr_valid && wr_ready_q;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        src_ram_d = src_ram_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
`ifdef IMEM_CHECKSUM_EN
        sum_d     = sum_q;
        sum_err_d = sum_err_q;
`endif
        if (reboot && state_q != S_HOLD_ROM) begin
            state_d   = S_HOLD_ROM;
            hold_d    = HOLD_INIT;
            count_d   = '0;
            ovf_d     = 1'b0;
            src_ram_d = 1'b0;
`ifdef IMEM_CHECKSUM_EN
            sum_d     = 16'h0000;
            sum_err_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_HOLD_ROM: begin
                    if (hold_q == 8'd0) begin
                        state_d = S_BOOT;
                    end else begin
                        hold_d = hold_q - 8'd1;
                    end
                end
                S_BOOT: begin
                    if (accept) begin
                        we_d    = 1'b1;
                        waddr_d = count_q[ADDR_W-1:0];
                        wdata_d = wr_data;
                        count_d = count_q + COUNT_ONE;
`ifdef IMEM_CHECKSUM_EN
                        sum_d   = sum_q + wr_data;
`endif
                    end else if (wr_valid) begin
                        ovf_d = 1'b1;
                    end
                    if (boot_done) begin
                        hold_d = HOLD_INIT;
`ifdef IMEM_CHECKSUM_EN
                        if (sum_d != expected_sum) begin
                            state_d   = S_ERROR;
                            sum_err_d = 1'b1;
                        end else
`endif
                        begin
                            state_d   = S_HOLD_RAM;
                            src_ram_d = 1'b1;
                        end
                    end
                end
                S_HOLD_RAM: begin
                    if (hold_q == 8'd0) begin
                        state_d = S_RUN;
                    end else begin
                        hold_d = hold_q - 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end

        // Outputs are registered from the next state so they change on the transition edge.
        cpu_reset_d = (state_d != S_BOOT) && (state_d != S_RUN);
        wr_ready_d  = (state_d == S_BOOT) && (count_d < FULL_COUNT);
        run_mode_d  = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_HOLD_ROM;
            hold_q      <= HOLD_INIT;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            src_ram_q   <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= 16'h0000;
            cpu_reset_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            run_mode_q  <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            sum_q       <= 16'h0000;
            sum_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            src_ram_q   <= src_ram_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            wr_ready_q  <= wr_ready_d;
            run_mode_q  <= run_mode_d;
`ifdef IMEM_CHECKSUM_EN
            sum_q       <= sum_d;
            sum_err_q   <= sum_err_d;
`endif
        end
    end

    // Fetch source only flips on entry to a hold state, while the CPU is held in reset.
    assign instruction = src_ram_q ? ram_rdata : rom_data;
    assign rom_addr    = pc[7:0];
    assign ram_raddr   = pc[ADDR_W-1:0];

    assign ram_we      = we_q;
    assign ram_waddr   = waddr_q;
    assign ram_wdata   = wdata_q;
    assign wr_ready    = wr_ready_q;
    assign cpu_reset   = cpu_reset_q;
    assign run_mode    = run_mode_q;
    assign overflow    = ovf_q;
    assign word_count  = count_q;
    assign state_dbg   = state_q;
`ifdef IMEM_CHECKSUM_EN
    assign sum_error   = sum_err_q;
`endif

    logic unused_pc;
    assign unused_pc = ^pc;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a phase/timer model and a write scoreboard.
module tb_imem_boot_ctrl;

    localparam int ADDR_W = 2;
    localparam int RC     = 4;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int P_HROM = 0, P_BOOT = 1, P_HRAM = 2, P_RUN = 3, P_ERR = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [15:0]       pc, instruction, rom_data, ram_rdata, ram_wdata, wr_data;
    logic [7:0]        rom_addr;
    logic [ADDR_W-1:0] ram_raddr, ram_waddr;
    logic              ram_we, wr_valid, wr_ready, boot_done, reboot;
    logic              cpu_reset, run_mode, overflow;
    logic [ADDR_W:0]   word_count;
    logic [2:0]        state_dbg;
`ifdef IMEM_CHECKSUM_EN
    logic [15:0]       expected_sum;
    logic              sum_error;
`endif

    always #5 clk = ~clk;

    imem_boot_ctrl #(.ADDR_W(ADDR_W), .RESET_CYCLES(RC)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .instruction(instruction),
        .rom_addr(rom_addr), .rom_data(rom_data), .ram_raddr(ram_raddr),
        .ram_rdata(ram_rdata), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .boot_done(boot_done), .reboot(reboot),
        .cpu_reset(cpu_reset), .run_mode(run_mode), .overflow(overflow),
        .word_count(word_count),
`ifdef IMEM_CHECKSUM_EN
        .expected_sum(expected_sum), .sum_error(sum_error),
`endif
        .state_dbg(state_dbg)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase plus cycles-spent-in-phase, word counter, and expected writes.
    int                m_phase, m_t, m_cnt;
    bit                m_ovf, m_src, m_we, m_serr, m_valid;
    logic [ADDR_W-1:0] m_waddr;
    logic [15:0]       m_wdata, m_sum;
    logic [ADDR_W+15:0] exp_q[$];
    logic [15:0]       ram_img [DEPTH];
    bit                m_acc;

    initial m_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = P_HROM; m_t = 0; m_cnt = 0; m_ovf = 0; m_src = 0; m_we = 0;
            m_waddr = '0; m_wdata = 16'h0; m_sum = 16'h0; m_serr = 0; m_valid = 1;
            exp_q.delete();
        end else begin
            m_acc = (m_phase == P_BOOT) && wr_valid && (m_cnt < DEPTH);
            m_we  = 0;
            if (reboot && m_phase != P_HROM) begin
                m_phase = P_HROM; m_t = 0; m_cnt = 0; m_ovf = 0; m_src = 0;
                m_sum = 16'h0; m_serr = 0;
            end else if (m_phase == P_HROM || m_phase == P_HRAM) begin
                m_t++;
                if (m_t == RC) begin
                    m_phase = (m_phase == P_HROM) ? P_BOOT : P_RUN;
                    m_t = 0;
                end
            end else if (m_phase == P_BOOT) begin
                if (m_acc) begin
                    m_we = 1; m_waddr = ADDR_W'(m_cnt); m_wdata = wr_data;
                    exp_q.push_back({m_waddr, m_wdata});
                    m_cnt++;
                    m_sum = m_sum + wr_data;
                end else if (wr_valid) begin
                    m_ovf = 1;
                end
                if (boot_done) begin
                    m_t = 0;
`ifdef IMEM_CHECKSUM_EN
                    if (m_sum != expected_sum) begin
                        m_phase = P_ERR; m_serr = 1;
                    end else begin
                        m_phase = P_HRAM; m_src = 1;
                    end
`else
                    m_phase = P_HRAM; m_src = 1;
`endif
                end
            end
        end
    end

    logic [ADDR_W+15:0] exp_w;

    always @(negedge clk) begin
        if (m_valid) begin
            check("cpu_reset", 32'(cpu_reset), 32'(m_phase == P_HROM || m_phase == P_HRAM || m_phase == P_ERR));
            check("wr_ready", 32'(wr_ready), 32'(m_phase == P_BOOT && m_cnt < DEPTH));
            check("run_mode", 32'(run_mode), 32'(m_phase == P_RUN));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("word_count", 32'(word_count), 32'(m_cnt));
            check("state_dbg", 32'(state_dbg), 32'(m_phase));
            check("ram_we", 32'(ram_we), 32'(m_we));
            check("ram_waddr", 32'(ram_waddr), 32'(m_waddr));
            check("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
            check("instruction", 32'(instruction), 32'(m_src ? ram_rdata : rom_data));
            check("rom_addr", 32'(rom_addr), 32'(pc[7:0]));
            check("ram_raddr", 32'(ram_raddr), 32'(pc[ADDR_W-1:0]));
`ifdef IMEM_CHECKSUM_EN
            check("sum_error", 32'(sum_error), 32'(m_serr));
`endif
            if (ram_we) begin
                check("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    exp_w = exp_q.pop_front();
                    check("ram_write", 32'({ram_waddr, ram_wdata}), 32'(exp_w));
                end
                ram_img[ram_waddr] = ram_wdata;
            end
        end
    end

    task automatic drive(input bit v, input logic [15:0] d, input bit done, input bit rb);
        wr_valid = v; wr_data = d; boot_done = done; reboot = rb;
        pc = 16'($urandom); rom_data = 16'($urandom); ram_rdata = 16'($urandom);
        @(posedge clk); #1;
        wr_valid = 1'b0; boot_done = 1'b0; reboot = 1'b0;
    endtask

    // Counts cycles with cpu_reset high, starting with the current one; bounded.
    task automatic hold_len(output int n);
        n = 0;
        while (cpu_reset && n < 50) begin
            n++;
            drive(1'b0, 16'h0, 1'b0, 1'b0);
        end
    endtask

    int n;

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = 16'h0; boot_done = 1'b0; reboot = 1'b0;
        pc = 16'h0; rom_data = 16'h0; ram_rdata = 16'h0;
`ifdef IMEM_CHECKSUM_EN
        expected_sum = 16'h6666;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_run_mode", 32'(run_mode), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        hold_len(n);
        check("rom_hold_len", 32'(n), 32'd4);
        check("boot_wr_ready", 32'(wr_ready), 32'd1);
        pc = 16'h0003; rom_data = 16'hBEEF; ram_rdata = 16'h1234;
        #1;
        check("rom_fetch", 32'(instruction), 32'hBEEF);
        check("rom_addr_lit", 32'(rom_addr), 32'h03);

        drive(1'b1, 16'h1111, 1'b0, 1'b0);
        check("w0_we", 32'(ram_we), 32'd1);
        check("w0_addr", 32'(ram_waddr), 32'd0);
        drive(1'b1, 16'h2222, 1'b0, 1'b0);
        check("w1_addr", 32'(ram_waddr), 32'd1);
        drive(1'b1, 16'h3333, 1'b0, 1'b0);
        check("w2_addr", 32'(ram_waddr), 32'd2);
        check("w2_data", 32'(ram_wdata), 32'h3333);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        check("done_we_off", 32'(ram_we), 32'd0);
        check("done_count", 32'(word_count), 32'd3);
        hold_len(n);
        check("ram_hold_len", 32'(n), 32'd4);
        check("run_mode_on", 32'(run_mode), 32'd1);
        check("img0", 32'(ram_img[0]), 32'h1111);
        check("img1", 32'(ram_img[1]), 32'h2222);
        check("img2", 32'(ram_img[2]), 32'h3333);
        pc = 16'h0001; rom_data = 16'hDEAD; ram_rdata = 16'h5A5A;
        #1;
        check("ram_fetch", 32'(instruction), 32'h5A5A);

        drive(1'b1, 16'hFFFF, 1'b1, 1'b0);
        check("run_ignore_we", 32'(ram_we), 32'd0);
        check("run_ignore_mode", 32'(run_mode), 32'd1);
        check("run_ignore_count", 32'(word_count), 32'd3);

        drive(1'b0, 16'h0, 1'b0, 1'b1);
        check("reboot_cpu_reset", 32'(cpu_reset), 32'd1);
        check("reboot_count", 32'(word_count), 32'd0);
        check("reboot_run_mode", 32'(run_mode), 32'd0);
        rom_data = 16'hC0DE; ram_rdata = 16'h0BAD;
        #1;
        check("reboot_rom_fetch", 32'(instruction), 32'hC0DE);
        hold_len(n);
        check("reboot_hold_len", 32'(n), 32'd4);
        check("reboot_wr_ready", 32'(wr_ready), 32'd1);

        for (int i = 0; i < 4; i++) drive(1'b1, 16'(16'hA000 + i), 1'b0, 1'b0);
        check("full_count", 32'(word_count), 32'd4);
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        drive(1'b1, 16'hA004, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_no_we", 32'(ram_we), 32'd0);
        check("ovf_count", 32'(word_count), 32'd4);

        drive(1'b0, 16'h0, 1'b0, 1'b1);
        check("ovf_cleared", 32'(overflow), 32'd0);
        hold_len(n);
`ifdef IMEM_CHECKSUM_EN
        expected_sum = 16'hFFFF;
`endif
        drive(1'b1, 16'h7777, 1'b0, 1'b0);
        drive(1'b1, 16'h8888, 1'b1, 1'b0);
        check("same_cycle_we", 32'(ram_we), 32'd1);
        check("same_cycle_addr", 32'(ram_waddr), 32'd1);
        check("same_cycle_data", 32'(ram_wdata), 32'h8888);
        check("same_cycle_state", 32'(state_dbg), 32'(P_HRAM));
        hold_len(n);

`ifdef IMEM_CHECKSUM_EN
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        hold_len(n);
        expected_sum = 16'h0004;
        drive(1'b1, 16'h0001, 1'b0, 1'b0);
        drive(1'b1, 16'h0002, 1'b1, 1'b0);
        check("sum_error_set", 32'(sum_error), 32'd1);
        check("sum_state_err", 32'(state_dbg), 32'(P_ERR));
        repeat (10) drive(1'b0, 16'h0, 1'b0, 1'b0);
        check("err_cpu_reset", 32'(cpu_reset), 32'd1);
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        check("err_exit_state", 32'(state_dbg), 32'(P_HROM));
        check("err_exit_flag", 32'(sum_error), 32'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            bit          v, dn, rb;
            logic [15:0] d;
            v  = ($urandom_range(0, 3) != 0);
            d  = 16'($urandom);
            dn = ($urandom_range(0, 19) == 0);
            rb = ($urandom_range(0, 79) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
`ifdef IMEM_CHECKSUM_EN
            if ($urandom_range(0, 1) == 1)
                expected_sum = m_sum + ((v && m_phase == P_BOOT && m_cnt < DEPTH) ? d : 16'h0);
            else
                expected_sum = 16'($urandom);
`endif
            drive(v, d, dn, rb);
        end
        rst_n = 1'b1;
        repeat (3) drive(1'b0, 16'h0, 1'b0, 1'b0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
